serial_comparator: RTL and testbench
====================================

Name: serial_comparator

Overview:
Bit-serial counterpart of the parallel 4-bit comparator. Operands A and B arrive one bit per accepted beat, MSB first, behind a start/valid handshake. After the final bit, a registered lt/eq/gt relation and a one-cycle done pulse are produced. Used where operands come from a serial link or shift register, so no WIDTH-bit parallel buses are needed.

Parameters:
WIDTH, 4, operand width in bits; legal range 2..32.
CNT_W, 5, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  begin a new comparison; sampled on a clk edge
bit_valid  input  1  a_bit/b_bit carry a valid operand bit this cycle
a_bit  input  1  current bit of A, MSB first
b_bit  input  1  current bit of B, MSB first
busy  output  1  1 while in RECV
done  output  1  one-cycle pulse; result valid
lt  output  1  A < B, held from done until next done/reset
eq  output  1  A == B, held likewise
gt  output  1  A > B, held likewise
Out  output  1  alias of lt

Behaviour:
- Reset (reset=0, async): state=IDLE; cnt=0; decided=0; busy=0; done=0; lt=0; eq=0; gt=0; Out=0. Takes effect immediately and overrides every other input.
- IDLE:
  - start=1 -> RECV; cnt=0; decided=0; internal relation=EQ.
  - bit_valid is ignored.
- RECV (busy=1):
  - Each cycle with bit_valid=1 consumes one bit pair and increments cnt.
  - While decided=0 and a_bit!=b_bit: set decided=1 and relation=(a_bit ? GT : LT).
  - Once decided=1, later bits are consumed but do not change the relation.
  - bit_valid=0 is a stall; state, cnt and relation hold indefinitely. There is no timeout.
  - When bit_valid=1 and cnt==WIDTH-1 -> DONE. The final relation (including the current bit) is loaded into lt/eq/gt on that same edge.
  - start=1 in RECV restarts: cnt=0, decided=0, relation=EQ. A bit_valid on the same cycle is discarded. No done is issued for the aborted operation.
- DONE (exactly one cycle):
  - done=1, busy=0; exactly one of lt/eq/gt is 1.
  - Next state is IDLE. If start=1 in DONE, next state is RECV, as from IDLE.
- Latency: done is high in the cycle immediately after the edge that accepts the WIDTH-th valid bit. Minimum total is WIDTH+2 cycles from the start edge.
- lt/eq/gt/Out change only on entry to DONE or on reset. They hold through IDLE and the next RECV.
- Simultaneous start and bit_valid in IDLE: start wins; the bit is discarded.
- cnt never exceeds WIDTH-1. All outputs are registered; there are no combinational input-to-output paths.

Optional Feature:
Macro SERIAL_CMP_SIGNED_EN.
- Defined: operands are two's complement. When the first differing bit is the MSB (cnt==0), relation=(a_bit ? LT : GT). Bits at cnt>0 use the unsigned rule.
- Not defined: purely unsigned comparison. The port list is identical in both builds.

Test Plan:
1. WIDTH=4; start; bits A=0001, B=1110, continuous valid -> done pulses in the 6th cycle after start. Unsigned build: lt=1, Out=1, eq=0, gt=0. Signed build: gt=1 (1 > -2).
2. A=1111, B=1111 -> done; eq=1, lt=0, gt=0. A=0000, B=0000 -> eq=1. Both cases identical in signed and unsigned builds.
3. A=1110, B=1011 -> gt=1 in both builds (14>11; -2>-5). A=1111, B=1110 -> gt=1 in both builds.
4. A=0110, B=0111 with bit_valid=0 for 3 cycles between bits 2 and 3 -> busy stays 1 across the stalls; done asserted exactly 1 cycle after the 4th valid bit; lt=1.
5. start; 2 bits of 10 vs 01; start again; full A=0001, B=0000 -> single done pulse only; gt=1; the aborted first attempt leaves no trace.
6. reset=0 asserted asynchronously mid-RECV after 2 bits -> busy, done, lt, eq, gt go to 0 immediately. After release, bit_valid pulses without start produce no done. A fresh start runs normally.

Source files
------------

// File: rtl/serial_comparator.sv
// Bit-serial magnitude comparator: operands arrive MSB first behind a start/valid
// handshake; a registered lt/eq/gt result and a done pulse follow the last bit.
// Define SERIAL_CMP_SIGNED_EN for two's-complement operands (default: unsigned).
module serial_comparator #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic bit_valid,
    input  logic a_bit,
    input  logic b_bit,
    output logic busy,
    output logic done,
    output logic lt,
    output logic eq,
    output logic gt,
    output logic Out
);

    typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;
    typedef enum logic [1:0] {REL_EQ, REL_LT, REL_GT} rel_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state, state_n;
    rel_t             rel, rel_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             decided, decided_n;
    logic             load;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_n   = state;
        cnt_n     = cnt;
        decided_n = decided;
        rel_n     = rel;
        load      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n   = RECV;
                    cnt_n     = '0;
                    decided_n = 1'b0;
                    rel_n     = REL_EQ;
                end
            end
            RECV: begin
                if (start) begin
                    // Restart discards any bit presented in the same cycle.
                    cnt_n     = '0;
                    decided_n = 1'b0;
                    rel_n     = REL_EQ;
                end else if (bit_valid) begin
                    if (!decided && (a_bit != b_bit)) begin
                        decided_n = 1'b1;
                        rel_n     = a_bit ? REL_GT : REL_LT;
`ifdef SERIAL_CMP_SIGNED_EN
                        // A set sign bit means a negative operand, so the MSB sense is inverted.
                        if (cnt == '0) rel_n = a_bit ? REL_LT : REL_GT;
`endif
                    end
                    if (cnt == LAST) begin
                        state_n = DONE;
                        cnt_n   = '0;
                        load    = 1'b1;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                if (start) begin
                    state_n   = RECV;
                    cnt_n     = '0;
                    decided_n = 1'b0;
                    rel_n     = REL_EQ;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            decided <= 1'b0;
            rel     <= REL_EQ;
            lt      <= 1'b0;
            eq      <= 1'b0;
            gt      <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            decided <= decided_n;
            rel     <= rel_n;
            if (load) begin
                lt <= (rel_n == REL_LT);
                eq <= (rel_n == REL_EQ);
                gt <= (rel_n == REL_GT);
            end
        end
    end

    assign busy = (state == RECV);
    assign done = (state == DONE);
    assign Out  = lt;

endmodule

// File: tb/tb_serial_comparator.sv
// Randomized self-checking bench for serial_comparator: an arithmetic reference model
// plus directed cases with hand-computed expectations.
module tb_serial_comparator;

    localparam int WIDTH = 4;
    localparam int CNT_W = 5;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic bit_valid = 1'b0;
    logic a_bit = 1'b0;
    logic b_bit = 1'b0;
    logic busy, done, lt, eq, gt, Out;

    int n_cmp = 0;
    int n_bad = 0;

    serial_comparator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bit_valid(bit_valid),
        .a_bit    (a_bit),
        .b_bit    (b_bit),
        .busy     (busy),
        .done     (done),
        .lt       (lt),
        .eq       (eq),
        .gt       (gt),
        .Out      (Out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference relation as {lt, eq, gt}, from plain integer comparison of the collected operands.
    function automatic logic [2:0] ref_rel(input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
`ifdef SERIAL_CMP_SIGNED_EN
        sa = $signed(a << (32 - WIDTH)) >>> (32 - WIDTH);
        sb = $signed(b << (32 - WIDTH)) >>> (32 - WIDTH);
`else
        sa = int'(a);
        sb = int'(b);
`endif
        return {sa < sb, sa == sb, sa > sb};
    endfunction

    // Model: collects operand bits into integers, decides the relation when WIDTH bits have arrived.
    logic        m_active = 1'b0;
    logic        m_done = 1'b0;
    logic        m_lt = 1'b0, m_eq = 1'b0, m_gt = 1'b0;
    int          m_n = 0;
    logic [31:0] m_a = '0, m_b = '0;

    always @(posedge clk or negedge reset) begin : model
        logic [31:0] na, nb;
        if (!reset) begin
            m_active <= 1'b0;
            m_done   <= 1'b0;
            m_n      <= 0;
            m_a      <= '0;
            m_b      <= '0;
            m_lt     <= 1'b0;
            m_eq     <= 1'b0;
            m_gt     <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_active <= 1'b1;
                m_n      <= 0;
                m_a      <= '0;
                m_b      <= '0;
            end else if (m_active && bit_valid) begin
                na = {m_a[30:0], a_bit};
                nb = {m_b[30:0], b_bit};
                m_a <= na;
                m_b <= nb;
                if (m_n == WIDTH - 1) begin
                    m_active <= 1'b0;
                    m_done   <= 1'b1;
                    m_n      <= 0;
                    {m_lt, m_eq, m_gt} <= ref_rel(na, nb);
                end else begin
                    m_n <= m_n + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("cycle", {26'd0, busy, done, lt, eq, gt, Out},
              {26'd0, m_active, m_done, m_lt, m_eq, m_gt, m_lt});
    end

    task automatic beat(input logic s, input logic v, input logic a, input logic b);
        @(negedge clk);
        start     = s;
        bit_valid = v;
        a_bit     = a;
        b_bit     = b;
    endtask

    // Full operation; stall_len idle cycles are inserted before bit index stall_at (MSB = WIDTH-1).
    task automatic send_op(input logic [31:0] a, input logic [31:0] b,
                           input int stall_at, input int stall_len);
        beat(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i == stall_at) begin
                for (int k = 0; k < stall_len; k++) begin
                    beat(1'b0, 1'b0, 1'b1, 1'b0);
                    check("stall_busy", {31'd0, busy}, 32'd1);
                end
            end
            beat(1'b0, 1'b1, a[i], b[i]);
        end
        @(negedge clk);
        start     = 1'b0;
        bit_valid = 1'b0;
    endtask

    task automatic check_result(input string name, input logic [3:0] exp_lt_eq_gt_out);
        check({name, "_done"}, {31'd0, done}, 32'd1);
        check({name, "_rel"}, {28'd0, lt, eq, gt, Out}, {28'd0, exp_lt_eq_gt_out});
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_state", {26'd0, busy, done, lt, eq, gt, Out}, 32'd0);
        reset = 1'b1;

        // Directed cases; expectations are {lt, eq, gt, Out}.
        send_op(32'b0001, 32'b1110, -1, 0);
`ifdef SERIAL_CMP_SIGNED_EN
        check_result("t1", 4'b0010);
`else
        check_result("t1", 4'b1001);
`endif
        send_op(32'b1111, 32'b1111, -1, 0);
        check_result("t2a", 4'b0100);
        send_op(32'b0000, 32'b0000, -1, 0);
        check_result("t2b", 4'b0100);
        send_op(32'b1110, 32'b1011, -1, 0);
        check_result("t3a", 4'b0010);
        send_op(32'b1111, 32'b1110, -1, 0);
        check_result("t3b", 4'b0010);
        send_op(32'b0110, 32'b0111, 0, 3);
        check_result("t4", 4'b1001);
        beat(1'b0, 1'b0, 1'b0, 1'b0);
        check("hold_after_done", {28'd0, lt, eq, gt, done}, {28'd0, 4'b1000});

        // Abort after two bits, then a full operation.
        beat(1'b1, 1'b0, 1'b0, 1'b0);
        beat(1'b0, 1'b1, 1'b1, 1'b0);
        beat(1'b0, 1'b1, 1'b0, 1'b1);
        send_op(32'b0001, 32'b0000, -1, 0);
        check_result("t5", 4'b0010);

        // Asynchronous reset mid-operation.
        beat(1'b1, 1'b0, 1'b0, 1'b0);
        beat(1'b0, 1'b1, 1'b0, 1'b1);
        beat(1'b0, 1'b1, 1'b1, 1'b1);
        #2 reset = 1'b0;
        #1 check("t6_async_reset", {27'd0, busy, done, lt, eq, gt}, 32'd0);
        beat(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        for (int i = 0; i < 2 * WIDTH; i++) beat(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
        beat(1'b0, 1'b0, 1'b0, 1'b0);
        check("t6_no_done", {30'd0, busy, done}, 32'd0);
        send_op(32'b0101, 32'b0101, -1, 0);
        check_result("t6_fresh", 4'b0100);

        // Randomized traffic checked cycle by cycle against the model.
        for (int c = 0; c < 3000; c++) begin
            logic s, a, b;
            s = m_active ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 2) == 0);
            a = 1'($urandom_range(0, 1));
            b = ($urandom_range(0, 3) == 0) ? ~a : a;
            beat(s, ($urandom_range(0, 3) != 0), a, b);
        end
        beat(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        #1 $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
